// File: rtl/prefetch_pkg.sv
// Shared prefetcher definitions: line geometry, default address width and line-address type.
// The best-offset prefetcher and the issue queue both draw on these.
package prefetch_pkg;

    localparam int PF_ADDR_WIDTH    = 64;
    localparam int PF_LINE_SIZE     = 256;
    localparam int PF_LINE_OFFSET_W = $clog2(PF_LINE_SIZE);

    typedef logic [PF_ADDR_WIDTH-PF_LINE_OFFSET_W-1:0] line_addr_t;

    function automatic line_addr_t line_of(input logic [PF_ADDR_WIDTH-1:0] addr);
        return addr[PF_ADDR_WIDTH-1:PF_LINE_OFFSET_W];
    endfunction

endpackage

// File: rtl/prefetch_issue_queue_if.sv
// Bundle of the prefetch issue queue's producer, demand and lower-cache signals.
interface prefetch_issue_queue_if #(
    parameter int WIDTH = prefetch_pkg::PF_ADDR_WIDTH,
    parameter int DEPTH = 8
);
    // pf_valid has no ready: the producer never stalls. Toward the lower cache a
    // request transfers on any rising edge where lo_prefetch_valid and lo_ready are both 1.
    logic [WIDTH-1:0]         pf_address;
    logic                     pf_valid;
    logic [WIDTH-1:0]         demand_address;
    logic                     demand_valid;
    logic                     lo_ready;
    logic [WIDTH-1:0]         lo_prefetch_address;
    logic                     lo_prefetch_valid;
    logic [$clog2(DEPTH):0]   occupancy;
    logic [15:0]              drop_count;

    modport master (
        output pf_address, pf_valid, demand_address, demand_valid, lo_ready,
        input  lo_prefetch_address, lo_prefetch_valid, occupancy, drop_count
    );

    modport slave (
        input  pf_address, pf_valid, demand_address, demand_valid, lo_ready,
        output lo_prefetch_address, lo_prefetch_valid, occupancy, drop_count
    );

endinterface

// File: rtl/prefetch_issue_queue_line_match.sv
// pq_line_match: DEPTH-way comparator of one line-aligned address against every
// valid queue slot; one match bit per slot.
module pq_line_match #(
    parameter int WIDTH = prefetch_pkg::PF_ADDR_WIDTH,
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0][WIDTH-1:0] slot_addr,
    input  logic [DEPTH-1:0]            slot_valid,
    input  logic [WIDTH-1:0]            line_addr,
    output logic [DEPTH-1:0]            match
);

    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        assign match[i] = slot_valid[i] && (slot_addr[i] == line_addr);
    end

endmodule

// File: rtl/prefetch_issue_queue.sv
// Issue queue between the best-offset prefetcher and the lower cache: deduplicates
// lines, drops on overflow, and lets demand misses cancel queued prefetches.
module prefetch_issue_queue
    import prefetch_pkg::*;
#(
    parameter int WIDTH     = PF_ADDR_WIDTH,
    parameter int DEPTH     = 8,
    parameter int LINE_SIZE = PF_LINE_SIZE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       pf_address_i,
    input  logic                   pf_valid_i,
    input  logic [WIDTH-1:0]       demand_address_i,
    input  logic                   demand_valid_i,
    input  logic                   lo_ready_i,
    output logic [WIDTH-1:0]       lo_prefetch_address_o,
    output logic                   lo_prefetch_valid_o,
    output logic [$clog2(DEPTH):0] occupancy_o,
    output logic [15:0]            drop_count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [WIDTH-1:0] OFF_MASK = WIDTH'(LINE_SIZE - 1);

    logic [DEPTH-1:0][WIDTH-1:0] slot_addr_q;
    logic [DEPTH-1:0]            slot_valid_q, slot_valid_d;
    logic [PTR_W-1:0]            head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [15:0]                 drop_q, drop_d;
    logic                        out_valid_q, out_valid_d;
    logic [WIDTH-1:0]            out_addr_q, out_addr_d;

    logic [WIDTH-1:0] pf_line, demand_line;
    logic [DEPTH-1:0] push_hits, demand_hits;
    logic             pop, retire, full, push_cand, push, drop;

    assign pf_line     = pf_address_i & ~OFF_MASK;
    assign demand_line = demand_address_i & ~OFF_MASK;

    pq_line_match #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_push_match (
        .slot_addr  (slot_addr_q),
        .slot_valid (slot_valid_q),
        .line_addr  (pf_line),
        .match      (push_hits)
    );

    pq_line_match #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_demand_match (
        .slot_addr  (slot_addr_q),
        .slot_valid (slot_valid_q),
        .line_addr  (demand_line),
        .match      (demand_hits)
    );

    // out_valid_q always equals (count_q != 0 && slot_valid_q[head_q]), so pop and
    // retire are mutually exclusive.
    always_comb begin
        pop       = out_valid_q && lo_ready_i;
        retire    = (count_q != '0) && !slot_valid_q[head_q];
        full      = (count_q == CNT_W'(DEPTH));
        push_cand = pf_valid_i && !(|push_hits)
                    && !(demand_valid_i && (pf_line == demand_line));
        push      = push_cand && (!full || pop || retire);
        drop      = push_cand && !push;

        slot_valid_d = slot_valid_q;
        if (demand_valid_i) begin
            slot_valid_d = slot_valid_d & ~demand_hits;
        end
        if (pop) begin
            slot_valid_d[head_q] = 1'b0;
        end
        if (push) begin
            slot_valid_d[tail_q] = 1'b1;
        end

        head_d  = (pop || retire) ? head_q + 1'b1 : head_q;
        tail_d  = push ? tail_q + 1'b1 : tail_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop || retire);
        drop_d  = (drop && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;

        // Outputs are registered from the next-state head so a lone push shows up
        // one cycle later and a demand hit on the head hides it from the next cycle.
        out_valid_d = (count_d != '0) && slot_valid_d[head_d];
        out_addr_d  = '0;
        if (count_d != '0) begin
            out_addr_d = (push && (tail_q == head_d)) ? pf_line : slot_addr_q[head_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            slot_valid_q <= '0;
            drop_q       <= '0;
            out_valid_q  <= 1'b0;
            out_addr_q   <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            slot_valid_q <= slot_valid_d;
            drop_q       <= drop_d;
            out_valid_q  <= out_valid_d;
            out_addr_q   <= out_addr_d;
        end
    end

    // Slot payloads need no reset: they are only observed behind a valid bit.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            slot_addr_q[tail_q] <= pf_line;
        end
    end

    assign lo_prefetch_valid_o   = out_valid_q;
    assign lo_prefetch_address_o = out_addr_q;
    assign occupancy_o           = count_q;
    assign drop_count_o          = drop_q;

endmodule

// File: tb/tb_prefetch_issue_queue.sv
// Bench for prefetch_issue_queue: a queue-of-entries reference model predicts issues
// into exp_q; a negedge monitor pops and compares whenever the DUT hands one over.
module tb_prefetch_issue_queue;
    import prefetch_pkg::*;

    localparam int W     = PF_ADDR_WIDTH;
    localparam int D     = 8;
    localparam int LINE  = PF_LINE_SIZE;

    typedef struct {
        logic [W-1:0] line;
        bit           live;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    prefetch_issue_queue_if #(.WIDTH(W), .DEPTH(D)) pif ();

    prefetch_issue_queue #(.WIDTH(W), .DEPTH(D), .LINE_SIZE(LINE)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .pf_address_i          (pif.pf_address),
        .pf_valid_i            (pif.pf_valid),
        .demand_address_i      (pif.demand_address),
        .demand_valid_i        (pif.demand_valid),
        .lo_ready_i            (pif.lo_ready),
        .lo_prefetch_address_o (pif.lo_prefetch_address),
        .lo_prefetch_valid_o   (pif.lo_prefetch_valid),
        .occupancy_o           (pif.occupancy),
        .drop_count_o          (pif.drop_count)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model + scoreboard state ----------------
    ent_t         mq[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] issued_log[$];
    logic [15:0]  m_drop = '0;
    bit           snap_valid;
    int           snap_occ;
    logic [15:0]  snap_drop;
    bit           checking = 0;
    int           tests_run = 0;
    int           tests_failed = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [W-1:0] align(input logic [W-1:0] a);
        logic [W-1:0] ls;
        ls = W'(LINE);
        return (a / ls) * ls;
    endfunction

    // Effect of one clock edge on the model, given the inputs held during that cycle.
    task automatic model_step(input bit r, input bit pv, input logic [W-1:0] pa,
                              input bit dv, input logic [W-1:0] da, input bit rdy);
        bit           issue, dup;
        logic [W-1:0] pl, dl;
        snap_valid = (mq.size() > 0) && mq[0].live;
        snap_occ   = mq.size();
        snap_drop  = m_drop;
        if (r) begin
            mq.delete();
            m_drop = '0;
            return;
        end
        pl    = align(pa);
        dl    = align(da);
        issue = snap_valid && rdy;
        dup   = 0;
        foreach (mq[i]) if (mq[i].live && mq[i].line == pl) dup = 1;
        if (dv) foreach (mq[i]) if (mq[i].line == dl) mq[i].live = 0;
        if (mq.size() > 0) begin
            if (issue) begin
                exp_q.push_back(mq[0].line);
                void'(mq.pop_front());
            end else if (!snap_valid) begin
                void'(mq.pop_front());
            end
        end
        if (pv && !dup && !(dv && pl == dl)) begin
            if (mq.size() < D) mq.push_back('{line: pl, live: 1'b1});
            else if (m_drop != 16'hFFFF) m_drop++;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input bit r, input bit pv, input logic [W-1:0] pa,
                        input bit dv, input logic [W-1:0] da, input bit rdy);
        @(posedge clk);
        #1;
        rst                = r;
        pif.pf_valid       = pv;
        pif.pf_address     = pa;
        pif.demand_valid   = dv;
        pif.demand_address = da;
        pif.lo_ready       = rdy;
        model_step(r, pv, pa, dv, da, rdy);
    endtask

    task automatic push(input logic [W-1:0] a, input bit rdy);
        step(0, 1, a, 0, '0, rdy);
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) step(0, 0, '0, 0, '0, rdy);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (checking) begin
            check("valid", 64'(pif.lo_prefetch_valid), 64'(snap_valid));
            check("occupancy", 64'(pif.occupancy), 64'(snap_occ));
            check("drop_count", 64'(pif.drop_count), 64'(snap_drop));
            if (!rst && pif.lo_prefetch_valid && pif.lo_ready) begin
                issued_log.push_back(pif.lo_prefetch_address);
                if (exp_q.size() == 0) begin
                    check("unexpected_issue", pif.lo_prefetch_address, 64'hDEAD_BEEF);
                end else begin
                    check("issue_addr", pif.lo_prefetch_address, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n0;
        bit seen9;
        pif.pf_valid       = 0;
        pif.pf_address     = '0;
        pif.demand_valid   = 0;
        pif.demand_address = '0;
        pif.lo_ready       = 0;

        step(1, 0, '0, 0, '0, 0);
        step(1, 0, '0, 0, '0, 0);
        checking = 1;
        idle(1, 0);
        check("reset_valid", 64'(pif.lo_prefetch_valid), 64'd0);
        check("reset_addr", pif.lo_prefetch_address, 64'd0);

        // single push into empty queue, ready high
        n0 = issued_log.size();
        push(64'h1234, 1);
        idle(1, 1);
        check("first_addr", pif.lo_prefetch_address, 64'h1200);
        check("first_valid", 64'(pif.lo_prefetch_valid), 64'd1);
        idle(1, 1);
        check("first_gone", 64'(pif.lo_prefetch_valid), 64'd0);
        check("first_occ", 64'(pif.occupancy), 64'd0);
        idle(1, 1);
        check("first_issue_cnt", 64'(issued_log.size() - n0), 64'd1);

        // same line twice while stalled
        n0 = issued_log.size();
        push(64'h1200, 0);
        push(64'h12FF, 0);
        idle(2, 0);
        check("dup_occ", 64'(pif.occupancy), 64'd1);
        idle(4, 1);
        check("dup_issue_cnt", 64'(issued_log.size() - n0), 64'd1);

        // overflow with nine distinct lines, then push while full and popping
        n0 = issued_log.size();
        for (int k = 0; k < 9; k++) push(64'h1000 * 64'(k + 1), 0);
        idle(1, 0);
        check("full_occ", 64'(pif.occupancy), 64'd8);
        check("full_drop", 64'(pif.drop_count), 64'd1);
        push(64'hA000, 1);
        idle(1, 0);
        check("full_swap_occ", 64'(pif.occupancy), 64'd8);
        check("full_swap_drop", 64'(pif.drop_count), 64'd1);
        idle(12, 1);
        check("overflow_issue_cnt", 64'(issued_log.size() - n0), 64'd9);
        seen9 = 0;
        for (int k = n0; k < issued_log.size(); k++) if (issued_log[k] == 64'h9000) seen9 = 1;
        check("ninth_never_issued", 64'(seen9), 64'd0);

        // demand miss cancels the middle entry
        n0 = issued_log.size();
        push(64'h20000, 0);
        push(64'h30000, 0);
        push(64'h40000, 0);
        step(0, 0, '0, 1, 64'h30010, 0);
        idle(6, 1);
        check("demand_issue_cnt", 64'(issued_log.size() - n0), 64'd2);
        if (issued_log.size() - n0 == 2) begin
            check("demand_first", issued_log[n0], 64'h20000);
            check("demand_second", issued_log[n0 + 1], 64'h40000);
        end
        check("demand_occ", 64'(pif.occupancy), 64'd0);

        // reset with five entries queued
        for (int k = 0; k < 5; k++) push(64'h50000 + 64'h100 * 64'(k), 0);
        idle(1, 0);
        check("pre_reset_occ", 64'(pif.occupancy), 64'd5);
        n0 = issued_log.size();
        step(1, 1, 64'h60000, 0, '0, 1);
        idle(1, 0);
        check("rst_valid", 64'(pif.lo_prefetch_valid), 64'd0);
        check("rst_occ", 64'(pif.occupancy), 64'd0);
        check("rst_drop", 64'(pif.drop_count), 64'd0);
        check("rst_addr", pif.lo_prefetch_address, 64'd0);
        push(64'h7777, 1);
        idle(3, 1);
        check("post_rst_issue_cnt", 64'(issued_log.size() - n0), 64'd1);

        // randomized traffic over a small line pool so duplicates and demand hits are common
        for (int c = 0; c < 1500; c++) begin
            logic [W-1:0] pa, da;
            pa = 64'h80000 + 64'($urandom_range(0, 11)) * 64'(LINE) + 64'($urandom_range(0, LINE - 1));
            da = 64'h80000 + 64'($urandom_range(0, 11)) * 64'(LINE) + 64'($urandom_range(0, LINE - 1));
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, pa,
                 $urandom_range(0, 4) == 0, da, $urandom_range(0, 2) == 0);
        end

        idle(20, 1);
        @(negedge clk);
        #1;
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("final_occ", 64'(pif.occupancy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/prefetch_issue_queue.md
PREFETCH_ISSUE_QUEUE -- requirements
Module: prefetch_issue_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 64: address width in bits.
REQ-002 SHALL have parameter DEPTH, default 8: queue entries, power of two, at least 2.
REQ-003 SHALL have parameter LINE_SIZE, default 256: line size in bytes, power of two.
REQ-004 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-006 SHALL have port pf_address_i  input  WIDTH: prefetch address from the best-offset prefetcher.
REQ-007 SHALL have port pf_valid_i  input  1: pf_address_i valid this cycle; no back-pressure to the producer.
REQ-008 SHALL have port demand_address_i  input  WIDTH: demand-miss address sent to the lower cache.
REQ-009 SHALL have port demand_valid_i  input  1: demand_address_i valid this cycle.
REQ-010 SHALL have port lo_ready_i  input  1: lower-level cache accepts a prefetch this cycle.
REQ-011 SHALL have port lo_prefetch_address_o  output  WIDTH: line-aligned prefetch address to the lower cache.
REQ-012 SHALL have port lo_prefetch_valid_o  output  1: lo_prefetch_address_o valid.
REQ-013 SHALL have port occupancy_o  output  $clog2(DEPTH)+1: number of allocated slots.
REQ-014 SHALL have port drop_count_o  output  16: requests dropped because the queue was full.

Function
REQ-015 SHALL line-align every stored address: low $clog2(LINE_SIZE) bits cleared.
REQ-016 SHALL implement a circular FIFO with head, tail and count registers, plus one valid bit per slot.
REQ-017 SHALL drive lo_prefetch_valid_o when count is not 0 and the head slot's valid bit is set; lo_prefetch_address_o is the head slot's address; both outputs come from registers only.
REQ-018 SHALL pop the head when lo_prefetch_valid_o and lo_ready_i are both 1, and present the next entry in the following cycle.
REQ-019 SHALL retire an invalidated head slot (count not 0, valid bit 0) without issuing it, one slot per cycle, with lo_prefetch_valid_o held at 0.
REQ-020 SHALL make a pushed request visible on the outputs one cycle after the push when the queue was empty: push in cycle N, valid in N+1.
REQ-021 SHALL silently discard a pushed request whose line matches any valid slot, including a head slot popping in the same cycle; the discard does not increment drop_count_o.
REQ-022 SHALL discard a pushed request whose line equals demand_address_i's line while demand_valid_i is 1 in the same cycle; the discard does not increment drop_count_o.
REQ-023 SHALL clear the valid bit of every slot whose line matches demand_address_i's line while demand_valid_i is 1; if that slot is the head, lo_prefetch_valid_o is 0 from the next cycle.
REQ-024 SHALL, when the queue is full, discard a new non-duplicate push and increment drop_count_o, saturating at 16'hFFFF.
REQ-025 SHALL accept a push when the queue is full if a pop or an invalid-head retire occurs in the same cycle.
REQ-026 SHALL wrap head and tail modulo DEPTH; count never exceeds DEPTH and never underflows.
REQ-027 SHALL make occupancy_o equal to count after the update.

Reset
REQ-028 SHALL, when rst is 1 at a clock edge, clear head, tail, count, all slot valid bits and drop_count_o; lo_prefetch_valid_o reads 0 and lo_prefetch_address_o reads 0 in the next cycle.
REQ-029 SHALL ignore all inputs in any cycle where rst is 1; reset mid-stream loses queued requests without issuing them.

Structure
REQ-030 SHALL take LINE_SIZE, the default WIDTH and the line-address typedef from shared package prefetch_pkg, also used by best_offset_prefetcher.
REQ-031 SHALL use one sub-module, pq_line_match: a combinational DEPTH-way line comparator returning a match vector, instantiated twice (push address, demand address).

Verification
REQ-032 SHALL cover: push 0x1234 into an empty queue with lo_ready_i=1 -> cycle N+1 output address 0x1200 with valid=1; cycle N+2 valid=0; occupancy back to 0.
REQ-033 SHALL cover: push 0x1200, then 0x12FF, with lo_ready_i=0 -> occupancy 1; one issue only after lo_ready_i rises.
REQ-034 SHALL cover: lo_ready_i=0, push 9 distinct lines with DEPTH=8 -> occupancy 8; drop_count_o=1; the 9th line is never issued.
REQ-035 SHALL cover: queue holds lines A, B, C and demand_valid_i hits B -> issue order A, C; B is never driven; occupancy reaches 0.
REQ-036 SHALL cover: queue full, lo_ready_i=1 and a push in the same cycle -> push accepted; occupancy stays 8; drop_count_o unchanged.
REQ-037 SHALL cover: assert rst with 5 entries queued -> next cycle valid=0, occupancy 0, drop_count_o 0; a later push issues normally.
